lut_neuron_prog: RTL and testbench

//  Run-time programmable truth-table neuron: the writer side of a fixed neuron LUT.
//  - Accepts a neuron truth table as a stream of config words and stores it.
//  - Once loaded, answers lookups (input index -> output code) with one cycle of latency.
//  - Lets a layer's neurons be reprogrammed in-system instead of resynthesised; one instance per neuron.

---
 rtl/lut_prog_pkg.sv | 28 ++
 rtl/lut_prog_table.sv | 51 +++++
 rtl/lut_neuron_prog.sv | 119 +++++++++++
 tb/tb_lut_neuron_prog.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lut_prog_pkg.sv
// Shared types and sizing helpers for the programmable LUT neuron.
package lut_prog_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2,
    ST_ERR   = 2'd3
  } state_e;

  // Number of table entries addressed by an IN_BITS index.
  function automatic int unsigned calc_depth(input int unsigned in_bits);
    return 32'(1) << in_bits;
  endfunction

  // Number of config words needed to fill the whole table.
  function automatic int unsigned calc_nwords(input int unsigned in_bits,
                                              input int unsigned out_bits,
                                              input int unsigned word_w);
    return (calc_depth(in_bits) * out_bits) / word_w;
  endfunction

  // Bit width needed to index n items, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lut_prog_table.sv
// Flop-array truth table: word-wide write port, registered entry-wide read port.
module lut_prog_table
  import lut_prog_pkg::*;
#(
  parameter int unsigned IN_BITS  = 6,
  parameter int unsigned OUT_BITS = 1,
  parameter int unsigned WORD_W   = 8,
  parameter int unsigned PTR_W    = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_wr_en,
  input  logic [PTR_W-1:0]    i_wr_ptr,
  input  logic [WORD_W-1:0]   i_wr_data,
  input  logic                i_rd_en,
  input  logic [IN_BITS-1:0]  i_rd_idx,
  output logic [OUT_BITS-1:0] o_rd_data
);

  localparam int unsigned DEPTH = calc_depth(IN_BITS);
  localparam int unsigned MEM_W = DEPTH * OUT_BITS;
  localparam int unsigned AW    = clog2_min1(MEM_W);

  logic [MEM_W-1:0]    r_mem;
  logic [OUT_BITS-1:0] r_rd_data;
  logic [AW-1:0]       w_wr_base;
  logic [AW-1:0]       w_rd_base;

  assign w_wr_base = AW'(i_wr_ptr) * AW'(WORD_W);
  assign w_rd_base = AW'(i_rd_idx) * AW'(OUT_BITS);
  assign o_rd_data = r_rd_data;

  // Table storage; reset clears every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem <= '0;
    end else if (i_wr_en) begin
      r_mem[w_wr_base +: WORD_W] <= i_wr_data;
    end
  end

  // Registered read; holds the last result when no read is requested.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[w_rd_base +: OUT_BITS];
    end
  end

endmodule

// File: rtl/lut_neuron_prog.sv
// Run-time programmable truth-table neuron: config-stream loader plus one-cycle lookup.
module lut_neuron_prog
  import lut_prog_pkg::*;
#(
  parameter int unsigned IN_BITS  = 6,
  parameter int unsigned OUT_BITS = 1,
  parameter int unsigned WORD_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_start,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [WORD_W-1:0]   cfg_data,
  input  logic                cfg_last,
  output logic                cfg_done,
  output logic                cfg_err,
  output logic                tbl_ok,
  input  logic                in_valid,
  input  logic [IN_BITS-1:0]  in_data,
  output logic                out_valid,
  output logic [OUT_BITS-1:0] out_data
);

  localparam int unsigned NWORDS = calc_nwords(IN_BITS, OUT_BITS, WORD_W);
  localparam int unsigned PTR_W  = clog2_min1(NWORDS);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [PTR_W-1:0] r_ptr;
  logic             r_cfg_done;
  logic             r_out_valid;
  logic             w_accept;
  logic             w_final;
  logic             w_lookup;

  // A word is never taken in a cfg_start cycle, so a restart always begins at word 0.
  assign w_accept = (r_state == ST_LOAD) && cfg_valid && !cfg_start;
  assign w_final  = (r_ptr == PTR_W'(NWORDS - 1));
  assign w_lookup = (r_state == ST_READY) && in_valid && !cfg_start;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; cfg_start overrides everything and restarts the load.
  always_comb begin
    w_state_nxt = r_state;
    if (cfg_start) begin
      w_state_nxt = ST_LOAD;
    end else if (w_accept) begin
      if (cfg_last && w_final) begin
        w_state_nxt = ST_READY;
      end else if (cfg_last != w_final) begin
        w_state_nxt = ST_ERR;
      end
    end
  end

  // State-decoded outputs; cfg_ready also drops combinationally under cfg_start.
  always_comb begin
    cfg_ready = 1'b0;
    tbl_ok    = 1'b0;
    cfg_err   = 1'b0;
    case (r_state)
      ST_LOAD:  cfg_ready = !cfg_start;
      ST_READY: tbl_ok    = 1'b1;
      ST_ERR:   cfg_err   = 1'b1;
      default:  ;
    endcase
  end

  // Word pointer; stops at the final word since that word always leaves LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (cfg_start) begin
      r_ptr <= '0;
    end else if (w_accept && !cfg_last && !w_final) begin
      r_ptr <= r_ptr + 1'b1;
    end
  end

  // Load-complete pulse and lookup-valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg_done  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_cfg_done  <= w_accept && cfg_last && w_final;
      r_out_valid <= w_lookup;
    end
  end

  assign cfg_done  = r_cfg_done;
  assign out_valid = r_out_valid;

  lut_prog_table #(
    .IN_BITS  (IN_BITS),
    .OUT_BITS (OUT_BITS),
    .WORD_W   (WORD_W),
    .PTR_W    (PTR_W)
  ) u_table (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_accept),
    .i_wr_ptr  (r_ptr),
    .i_wr_data (cfg_data),
    .i_rd_en   (w_lookup),
    .i_rd_idx  (in_data),
    .o_rd_data (out_data)
  );

endmodule

// File: tb/tb_lut_neuron_prog.sv
// Directed self-checking bench for lut_neuron_prog at default parameters.
module tb_lut_neuron_prog;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_start;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_data;
  logic       cfg_last;
  logic       cfg_done;
  logic       cfg_err;
  logic       tbl_ok;
  logic       in_valid;
  logic [5:0] in_data;
  logic       out_valid;
  logic [0:0] out_data;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  lut_neuron_prog dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
    .cfg_last  (cfg_last),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .tbl_ok    (tbl_ok),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  // Count cfg_done pulses as seen mid-cycle.
  always @(negedge clk) if (cfg_done === 1'b1) done_cnt++;

  // Drivers below start and end just after a falling edge.
  task automatic pulse_start();
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic load_words(input logic [63:0] tbl, input int n, input int last_idx,
                            input bit with_start);
    if (with_start) pulse_start();
    for (int i = 0; i < n; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = tbl[i*8 +: 8];
      cfg_last  = (i == last_idx);
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    cfg_data  = 8'h00;
  endtask

  task automatic do_lookup(input logic [5:0] idx, output logic ov, output logic od);
    in_valid = 1'b1;
    in_data  = idx;
    @(negedge clk);
    in_valid = 1'b0;
    ov = out_valid;
    od = out_data[0];
  endtask

  task automatic test_reset();
    logic [5:0] outs;
    rst_n = 1'b0; cfg_start = 0; cfg_valid = 0; cfg_data = 0; cfg_last = 0;
    in_valid = 0; in_data = 0;
    repeat (2) @(negedge clk);
    outs = {cfg_ready, cfg_done, cfg_err, tbl_ok, out_valid, out_data[0]};
    checks++;
    if (outs !== 6'b0) begin failures++; $display("FAIL reset_outs: got %b want 000000", outs); end
    rst_n = 1'b1;
    @(negedge clk);
    outs = {cfg_ready, cfg_done, cfg_err, tbl_ok, out_valid, out_data[0]};
    checks++;
    if (outs !== 6'b0) begin failures++; $display("FAIL idle_outs: got %b want 000000", outs); end
  endtask

  task automatic test_load_lookup();
    int d0; logic ov, od;
    d0 = done_cnt;
    load_words({8{8'hA5}}, 8, 7, 1'b1);
    @(negedge clk);
    checks++;
    if (done_cnt - d0 != 1) begin failures++; $display("FAIL load_done_cnt: got %0d want 1", done_cnt - d0); end
    checks++;
    if (cfg_done !== 1'b0) begin failures++; $display("FAIL done_single: got %b want 0", cfg_done); end
    checks++;
    if (tbl_ok !== 1'b1 || cfg_ready !== 1'b0 || cfg_err !== 1'b0) begin
      failures++; $display("FAIL ready_flags: got ok=%b rdy=%b err=%b want 1 0 0", tbl_ok, cfg_ready, cfg_err);
    end
    do_lookup(6'd0, ov, od);
    checks++;
    if (ov !== 1'b1 || od !== 1'b1) begin failures++; $display("FAIL lookup_0: got v=%b d=%b want 1 1", ov, od); end
    do_lookup(6'd1, ov, od);
    checks++;
    if (ov !== 1'b1 || od !== 1'b0) begin failures++; $display("FAIL lookup_1: got v=%b d=%b want 1 0", ov, od); end
    do_lookup(6'd63, ov, od);
    checks++;
    if (ov !== 1'b1 || od !== 1'b1) begin failures++; $display("FAIL lookup_63: got v=%b d=%b want 1 1", ov, od); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_data[0] !== 1'b1) begin
      failures++; $display("FAIL out_hold: got v=%b d=%b want 0 1", out_valid, out_data[0]);
    end
  endtask

  task automatic test_early_last();
    logic ov, od;
    load_words({8{8'h3C}}, 3, 2, 1'b1);
    checks++;
    if (cfg_err !== 1'b1 || tbl_ok !== 1'b0 || cfg_ready !== 1'b0) begin
      failures++; $display("FAIL early_last: got err=%b ok=%b rdy=%b want 1 0 0", cfg_err, tbl_ok, cfg_ready);
    end
    do_lookup(6'd0, ov, od);
    checks++;
    if (ov !== 1'b0) begin failures++; $display("FAIL err_lookup_valid: got %b want 0", ov); end
    pulse_start();
    #1;
    checks++;
    if (cfg_err !== 1'b0 || cfg_ready !== 1'b1) begin
      failures++; $display("FAIL restart_clears_err: got err=%b rdy=%b want 0 1", cfg_err, cfg_ready);
    end
  endtask

  task automatic test_missing_last();
    int d0;
    d0 = done_cnt;
    load_words({8{8'hFF}}, 8, -1, 1'b1);
    @(negedge clk);
    checks++;
    if (cfg_err !== 1'b1 || tbl_ok !== 1'b0) begin
      failures++; $display("FAIL missing_last: got err=%b ok=%b want 1 0", cfg_err, tbl_ok);
    end
    checks++;
    if (done_cnt != d0) begin failures++; $display("FAIL missing_last_done: got %0d pulses want 0", done_cnt - d0); end
  endtask

  task automatic test_stream();
    load_words(64'h0000_0000_0000_0001, 8, 7, 1'b1);
    checks++;
    if (tbl_ok !== 1'b1) begin failures++; $display("FAIL stream_load: got ok=%b want 1", tbl_ok); end
    for (int i = 0; i <= 64; i++) begin
      if (i > 0) begin
        checks++;
        if (out_valid !== 1'b1 || out_data[0] !== ((i - 1) == 0)) begin
          failures++;
          $display("FAIL stream_idx%0d: got v=%b d=%b want 1 %0d", i - 1, out_valid, out_data[0], (i - 1) == 0);
        end
      end
      if (i < 64) begin
        in_valid = 1'b1;
        in_data  = 6'(i);
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_start_abort();
    int d0; logic ov, od;
    // Restart from READY with a lookup and a word in the same cycle.
    cfg_start = 1'b1; in_valid = 1'b1; in_data = 6'd0;
    cfg_valid = 1'b1; cfg_data = 8'hFF;
    @(negedge clk);
    cfg_start = 1'b0; in_valid = 1'b0; cfg_valid = 1'b0; cfg_data = 8'h00;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data[0] !== 1'b0) begin
      failures++; $display("FAIL abort_lookup_dropped: got v=%b d=%b want 0 0", out_valid, out_data[0]);
    end
    checks++;
    if (tbl_ok !== 1'b0 || cfg_ready !== 1'b1) begin
      failures++; $display("FAIL abort_state: got ok=%b rdy=%b want 0 1", tbl_ok, cfg_ready);
    end
    @(negedge clk);
    // Restart inside LOAD with a word presented alongside.
    cfg_start = 1'b1; cfg_valid = 1'b1; cfg_data = 8'hFF;
    #1;
    checks++;
    if (cfg_ready !== 1'b0) begin failures++; $display("FAIL start_word_ready: got %b want 0", cfg_ready); end
    @(negedge clk);
    cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = 8'h00;
    d0 = done_cnt;
    load_words({8{8'h5A}}, 8, 7, 1'b0);
    @(negedge clk);
    checks++;
    if (tbl_ok !== 1'b1 || done_cnt - d0 != 1) begin
      failures++; $display("FAIL start_word_dropped: got ok=%b done=%0d want 1 1", tbl_ok, done_cnt - d0);
    end
    do_lookup(6'd0, ov, od);
    checks++;
    if (ov !== 1'b1 || od !== 1'b0) begin failures++; $display("FAIL reload_idx0: got v=%b d=%b want 1 0", ov, od); end
    do_lookup(6'd63, ov, od);
    checks++;
    if (ov !== 1'b1 || od !== 1'b0) begin failures++; $display("FAIL reload_idx63: got v=%b d=%b want 1 0", ov, od); end
    do_lookup(6'd62, ov, od);
    checks++;
    if (ov !== 1'b1 || od !== 1'b1) begin failures++; $display("FAIL reload_idx62: got v=%b d=%b want 1 1", ov, od); end
    do_lookup(6'd1, ov, od);
    checks++;
    if (ov !== 1'b1 || od !== 1'b1) begin failures++; $display("FAIL reload_idx1: got v=%b d=%b want 1 1", ov, od); end
  endtask

  task automatic test_reset_midload();
    logic [5:0] outs; logic ov, od; int d0;
    load_words({8{8'hFF}}, 4, -1, 1'b1);
    rst_n = 1'b0;
    #1;
    outs = {cfg_ready, cfg_done, cfg_err, tbl_ok, out_valid, out_data[0]};
    checks++;
    if (outs !== 6'b0) begin failures++; $display("FAIL midload_reset_outs: got %b want 000000", outs); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_lookup(6'd0, ov, od);
    checks++;
    if (ov !== 1'b0 || tbl_ok !== 1'b0) begin
      failures++; $display("FAIL post_reset_idle: got v=%b ok=%b want 0 0", ov, tbl_ok);
    end
    d0 = done_cnt;
    load_words(64'h0, 8, 7, 1'b1);
    @(negedge clk);
    checks++;
    if (tbl_ok !== 1'b1 || done_cnt - d0 != 1) begin
      failures++; $display("FAIL zero_reload: got ok=%b done=%0d want 1 1", tbl_ok, done_cnt - d0);
    end
    for (int k = 0; k < 4; k++) begin
      logic [5:0] idx;
      idx = 6'(k * 21);
      do_lookup(idx, ov, od);
      checks++;
      if (ov !== 1'b1 || od !== 1'b0) begin
        failures++; $display("FAIL zero_idx%0d: got v=%b d=%b want 1 0", idx, ov, od);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_lookup();
    test_early_last();
    test_missing_last();
    test_stream();
    test_start_abort();
    test_reset_midload();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
